// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares one single-port instruction memory (1-cycle read latency) between the
// fetch unit and the loader/debug port. Fetch has fixed priority while the
// memory is shared; the loader can take exclusive ownership for downloads.
// Optional feature: define STARVE_GUARD_EN to add a loader anti-starvation
// counter (MAX_WAIT consecutive denials force one loader grant).
// rst_n is a synchronous, ACTIVE-HIGH reset despite its name.

module imem_port_arbiter #(
    parameter int AW = 14,
    parameter int DW = 32
`ifdef STARVE_GUARD_EN
    ,
    parameter int MAX_WAIT = 8
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic          f_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          d_lock,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic          d_locked,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdata
);

    typedef enum logic [1:0] {
        SHARED    = 2'd0,
        LOCK_PEND = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Owner tag of the read launched last cycle; decides who sees rvalid.
    logic f_pend_reg;
    logic d_pend_reg;

    // High when the loader must beat fetch this cycle (starvation override).
    logic loader_first;

`ifdef STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_reg;
    logic [CW-1:0] wait_next;

    assign loader_first = (state_reg == SHARED) && d_req && (wait_reg == CW'(MAX_WAIT));

    // Denial counter: counts shared-mode loader denials, clears on any loader
    // grant, and saturates at MAX_WAIT so it can never wrap back to zero.
    always_comb begin
        wait_next = wait_reg;
        if (d_gnt) begin
            wait_next = '0;
        end else if ((state_reg == SHARED) && d_req && (wait_reg != CW'(MAX_WAIT))) begin
            wait_next = wait_reg + 1'b1;
        end
    end

    // Denial counter register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wait_reg <= '0;
        end else begin
            wait_reg <= wait_next;
        end
    end
`else
    assign loader_first = 1'b0;
`endif

    // Grant decision and next-state logic; nothing is granted while in reset.
    always_comb begin
        f_gnt      = 1'b0;
        d_gnt      = 1'b0;
        state_next = state_reg;
        if (!rst_n) begin
            case (state_reg)
                SHARED: begin
                    if (loader_first) begin
                        d_gnt = 1'b1;
                    end else if (f_req) begin
                        f_gnt = 1'b1;
                    end else if (d_req) begin
                        d_gnt = 1'b1;
                    end
                    if (d_lock) begin
                        state_next = LOCK_PEND;
                    end
                end
                LOCK_PEND: begin
                    // One idle cycle lets a read granted in SHARED return
                    // before the loader starts its exclusive accesses.
                    state_next = d_lock ? LOCKED : SHARED;
                end
                LOCKED: begin
                    d_gnt = d_req;
                    if (!d_lock) begin
                        state_next = SHARED;
                    end
                end
                default: begin
                    state_next = SHARED;
                end
            endcase
        end
    end

    // State register and read-owner tags.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg  <= SHARED;
            f_pend_reg <= 1'b0;
            d_pend_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            f_pend_reg <= f_gnt;
            d_pend_reg <= d_gnt & ~d_we;
        end
    end

    // Memory-side mux: the granted requester drives the macro, idle drives 0.
    always_comb begin
        mem_en    = f_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Requester-side status; all forced low while reset is held.
    always_comb begin
        f_rvalid = f_pend_reg & ~rst_n;
        d_rvalid = d_pend_reg & ~rst_n;
        d_locked = (state_reg == LOCKED) & ~rst_n;
        f_stall  = ~rst_n & ((f_req & ~f_gnt) | (state_reg != SHARED));
        rdata    = mem_rdata;
    end

endmodule
